// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the fetch, data and byte-wide RAM signals seen by mem_ctrl.
// Ports (signals): if_req/if_addr/if_flush/if_done/if_inst fetch port; dm_req/dm_we/dm_len/
//   dm_addr/dm_wdata/dm_done/dm_rdata data port; ram_din/ram_dout/ram_a/ram_wr RAM port; io_full.
// Modports: slave = controller side, master = requester/RAM side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_len;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_done;
    logic [31:0]       dm_rdata;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              io_full;

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_len, dm_addr, dm_wdata, ram_din, io_full,
        output if_done, if_inst, dm_done, dm_rdata, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_len, dm_addr, dm_wdata, ram_din, io_full,
        input  if_done, if_inst, dm_done, dm_rdata, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and data requests onto a byte-wide RAM, sequencing 1/2/4-byte
//   transfers one byte per cycle and assembling read data little-endian.
// Ports: clk, rst (synchronous, active-high); bus (mem_ctrl_if.slave) with fetch, data and RAM signals.
// Option: define MEMCTRL_IO_STALL_EN to hold IO-region stores (addr[17:16] == IO_SEL_HI) while io_full.
module mem_ctrl #(
    parameter int         ADDR_W    = 32,
    parameter logic [1:0] IO_SEL_HI = 2'b11
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
`ifdef MEMCTRL_IO_STALL_EN
    localparam logic IO_STALL = 1'b1;
`else
    localparam logic IO_STALL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        addr_cnt_q, addr_cnt_d, rcv_cnt_q, rcv_cnt_d, n_q, n_d;
    logic              armed_q, armed_d, is_if_q, is_if_d;
    logic [ADDR_W-1:0] base_q, base_d, ram_a_q, ram_a_d;
    logic [31:0]       wdata_q, wdata_d, rbuf_q, rbuf_d, if_inst_q, if_inst_d, dm_rdata_q, dm_rdata_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d, if_done_q, if_done_d, dm_done_q, dm_done_d;
    logic [31:0]       word, wshift;
    logic              dm_act, if_act, stall;

    // A held request is not re-accepted in the cycle its own done is showing.
    assign dm_act = bus.dm_req & ~dm_done_q;
    assign if_act = bus.if_req & ~if_done_q & ~bus.if_flush;
    assign stall  = IO_STALL & bus.dm_we & (bus.dm_addr[17:16] == IO_SEL_HI) & bus.io_full;
    // Word so far with the byte arriving this cycle merged into lane rcv_cnt.
    assign word   = rbuf_q | ({24'd0, bus.ram_din} << {rcv_cnt_q[1:0], 3'b000});
    assign wshift = wdata_q >> {addr_cnt_q[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            rcv_cnt_q  <= '0;
            n_q        <= '0;
            armed_q    <= 1'b0;
            is_if_q    <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_inst_q  <= '0;
            dm_done_q  <= 1'b0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            n_q        <= n_d;
            armed_q    <= armed_d;
            is_if_q    <= is_if_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            if_done_q  <= if_done_d;
            if_inst_q  <= if_inst_d;
            dm_done_q  <= dm_done_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        n_d        = n_q;
        armed_d    = armed_q;
        is_if_d    = is_if_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = ram_wr_q;
        if_done_d  = 1'b0;
        if_inst_d  = if_inst_q;
        dm_done_d  = 1'b0;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (dm_act && !stall) begin
                    base_d     = bus.dm_addr;
                    ram_a_d    = bus.dm_addr;
                    wdata_d    = bus.dm_wdata;
                    n_d        = bus.dm_len == 2'd0 ? 3'd1 : bus.dm_len == 2'd1 ? 3'd2 : 3'd4;
                    is_if_d    = 1'b0;
                    addr_cnt_d = 3'd1;
                    rcv_cnt_d  = 3'd0;
                    armed_d    = 1'b0;
                    rbuf_d     = '0;
                    ram_dout_d = bus.dm_we ? bus.dm_wdata[7:0] : ram_dout_q;
                    ram_wr_d   = bus.dm_we;
                    state_d    = bus.dm_we ? WRITE : READ;
                end else if (!dm_act && if_act) begin
                    base_d     = bus.if_addr;
                    ram_a_d    = bus.if_addr;
                    n_d        = 3'd4;
                    is_if_d    = 1'b1;
                    addr_cnt_d = 3'd1;
                    rcv_cnt_d  = 3'd0;
                    armed_d    = 1'b0;
                    rbuf_d     = '0;
                    ram_wr_d   = 1'b0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (is_if_q && bus.if_flush) begin
                    ram_a_d = '0;
                    state_d = IDLE;
                end else begin
                    if (addr_cnt_q < n_q) begin
                        ram_a_d    = base_q + ADDR_W'(addr_cnt_q);
                        addr_cnt_d = addr_cnt_q + 3'd1;
                    end
                    // RAM data lags its address by two edges, so skip the first edge.
                    if (!armed_q) begin
                        armed_d = 1'b1;
                    end else begin
                        rbuf_d    = word;
                        rcv_cnt_d = rcv_cnt_q + 3'd1;
                        if (rcv_cnt_q == n_q - 3'd1) begin
                            if_inst_d  = is_if_q ? word : if_inst_q;
                            if_done_d  = is_if_q;
                            dm_rdata_d = is_if_q ? dm_rdata_q : word;
                            dm_done_d  = ~is_if_q;
                            ram_a_d    = '0;
                            state_d    = IDLE;
                        end
                    end
                end
            end
            WRITE: begin
                if (addr_cnt_q < n_q) begin
                    ram_a_d    = base_q + ADDR_W'(addr_cnt_q);
                    ram_dout_d = wshift[7:0];
                    addr_cnt_d = addr_cnt_q + 3'd1;
                end else begin
                    ram_wr_d  = 1'b0;
                    ram_a_d   = '0;
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_a    = ram_a_q;
    assign bus.ram_dout = ram_dout_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_inst  = if_inst_q;
    assign bus.dm_done  = dm_done_q;
    assign bus.dm_rdata = dm_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a two-edge-latency byte RAM model.
module tb_mem_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] mem [0:1023];
    logic [9:0] a_d1;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_SEL_HI(2'b11)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // RAM returns the byte for the address the controller presented two edges earlier.
    always @(posedge clk) begin
        a_d1 <= bus.ram_a[9:0];
        if (bus.ram_wr) mem[bus.ram_a[9:0]] <= bus.ram_dout;
    end
    assign bus.ram_din = mem[a_d1];

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.ram_a !== 32'd0 || bus.ram_wr !== 1'b0 || bus.ram_dout !== 8'd0) begin
            errors++;
            $display("FAIL reset_ram: got a=%h wr=%b dout=%h expected 0/0/0", bus.ram_a, bus.ram_wr, bus.ram_dout);
        end
        checks++;
        if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || bus.if_inst !== 32'd0 || bus.dm_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_ports: got ifd=%b dmd=%b inst=%h rdata=%h expected zeros",
                     bus.if_done, bus.dm_done, bus.if_inst, bus.dm_rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (bus.if_done !== (k == 5)) begin
                errors++;
                $display("FAIL fetch_done edge%0d: got %b expected %b", k, bus.if_done, k == 5);
            end
            if (k < 4) begin
                checks++;
                if (bus.ram_a !== 32'h100 + k) begin
                    errors++;
                    $display("FAIL fetch_addr edge%0d: got %h expected %h", k, bus.ram_a, 32'h100 + k);
                end
            end
        end
        checks++;
        if (bus.if_inst !== 32'h0000_0513) begin
            errors++;
            $display("FAIL fetch_inst: got %h expected 00000513", bus.if_inst);
        end
        bus.if_req = 1'b0;
        step();
        checks++;
        if (bus.if_done !== 1'b0 || bus.ram_a !== 32'd0) begin
            errors++;
            $display("FAIL fetch_idle: got done=%b a=%h expected 0/0", bus.if_done, bus.ram_a);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] w;
        w           = 32'hDEAD_BEEF;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b1;
        bus.dm_len  = 2'd3;
        bus.dm_addr = 32'h20;
        bus.dm_wdata = w;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) begin
                checks++;
                if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h20 + k || bus.ram_dout !== w[8*k +: 8] || bus.dm_done !== 1'b0) begin
                    errors++;
                    $display("FAIL sw_byte edge%0d: got wr=%b a=%h d=%h done=%b expected 1/%h/%h/0",
                             k, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.dm_done, 32'h20 + k, w[8*k +: 8]);
                end
            end else begin
                checks++;
                if (bus.dm_done !== 1'b1 || bus.ram_wr !== 1'b0 || bus.ram_a !== 32'd0) begin
                    errors++;
                    $display("FAIL sw_done: got done=%b wr=%b a=%h expected 1/0/0", bus.dm_done, bus.ram_wr, bus.ram_a);
                end
            end
        end
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        step();
        bus.dm_req  = 1'b1;
        bus.dm_len  = 2'd0;
        bus.dm_addr = 32'h22;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.dm_done !== (k == 2)) begin
                errors++;
                $display("FAIL lb_done edge%0d: got %b expected %b", k, bus.dm_done, k == 2);
            end
        end
        checks++;
        if (bus.dm_rdata !== 32'h0000_00AD) begin
            errors++;
            $display("FAIL lb_data: got %h expected 000000ad", bus.dm_rdata);
        end
        bus.dm_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        int fetch_accepts;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_len  = 2'd1;
        bus.dm_addr = 32'h40;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.dm_done !== (k == 3) || bus.if_done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_lh edge%0d: got dmd=%b ifd=%b expected %b/0", k, bus.dm_done, bus.if_done, k == 3);
            end
        end
        checks++;
        if (bus.dm_rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL b2b_lh_data: got %h expected 00001234", bus.dm_rdata);
        end
        bus.dm_req = 1'b0;
        step();
        checks++;
        if (bus.ram_a !== 32'h100) begin
            errors++;
            $display("FAIL b2b_fetch_accept: got a=%h expected 00000100", bus.ram_a);
        end
        for (int k = 1; k < 6; k++) begin
            step();
            checks++;
            if (bus.if_done !== (k == 5)) begin
                errors++;
                $display("FAIL b2b_fetch_done edge%0d: got %b expected %b", k, bus.if_done, k == 5);
            end
        end
        checks++;
        if (bus.if_inst !== 32'h0000_0513) begin
            errors++;
            $display("FAIL b2b_inst: got %h expected 00000513", bus.if_inst);
        end
        // Request still held during the done cycle: must not start a second fetch.
        fetch_accepts = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.ram_a !== 32'd0 || bus.if_done !== 1'b0) fetch_accepts++;
            if (k == 0) bus.if_req = 1'b0;
        end
        checks++;
        if (fetch_accepts !== 0) begin
            errors++;
            $display("FAIL b2b_double_accept: got %0d busy cycles expected 0", fetch_accepts);
        end
    endtask

    task automatic test_flush;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int k = 0; k < 3; k++) step();
        bus.if_flush = 1'b1;
        step();
        checks++;
        if (bus.if_done !== 1'b0 || bus.ram_a !== 32'd0 || bus.if_inst !== 32'h0000_0513) begin
            errors++;
            $display("FAIL flush_abort: got done=%b a=%h inst=%h expected 0/0/00000513", bus.if_done, bus.ram_a, bus.if_inst);
        end
        bus.if_flush = 1'b0;
        bus.if_addr  = 32'h104;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (bus.if_done !== (k == 5)) begin
                errors++;
                $display("FAIL flush_target_done edge%0d: got %b expected %b", k, bus.if_done, k == 5);
            end
        end
        checks++;
        if (bus.if_inst !== 32'h0010_0093) begin
            errors++;
            $display("FAIL flush_target_inst: got %h expected 00100093", bus.if_inst);
        end
        bus.if_req = 1'b0;
        step();
        // Flush coinciding with the last-byte edge: no done, word not loaded.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int k = 0; k < 5; k++) step();
        bus.if_flush = 1'b1;
        step();
        checks++;
        if (bus.if_done !== 1'b0 || bus.if_inst !== 32'h0010_0093) begin
            errors++;
            $display("FAIL flush_last_edge: got done=%b inst=%h expected 0/00100093", bus.if_done, bus.if_inst);
        end
        bus.if_req   = 1'b0;
        bus.if_flush = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        int dones;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_len   = 2'd3;
        bus.dm_addr  = 32'h50;
        bus.dm_wdata = 32'h1122_3344;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.ram_a !== 32'd0 || bus.ram_wr !== 1'b0 || bus.ram_dout !== 8'd0 || bus.dm_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got a=%h wr=%b d=%h done=%b expected zeros",
                     bus.ram_a, bus.ram_wr, bus.ram_dout, bus.dm_done);
        end
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        rst        = 1'b0;
        dones      = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.dm_done !== 1'b0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_mid_done: got %0d dones expected 0", dones);
        end
        checks++;
        if (mem[10'h50] !== 8'h44 || mem[10'h51] !== 8'h33 || mem[10'h52] !== 8'h00 || mem[10'h53] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_partial: got %h %h %h %h expected 44 33 00 00",
                     mem[10'h50], mem[10'h51], mem[10'h52], mem[10'h53]);
        end
    endtask

    task automatic test_io_store;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_len   = 2'd0;
        bus.dm_addr  = 32'h0003_0000;
        bus.dm_wdata = 32'h0000_005A;
        bus.io_full  = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (bus.ram_wr !== 1'b0) begin
                errors++;
                $display("FAIL io_stall cycle%0d: got wr=%b expected 0", k, bus.ram_wr);
            end
        end
        bus.io_full = 1'b0;
`endif
        step();
        checks++;
        if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h0003_0000 || bus.ram_dout !== 8'h5A) begin
            errors++;
            $display("FAIL io_write: got wr=%b a=%h d=%h expected 1/00030000/5a", bus.ram_wr, bus.ram_a, bus.ram_dout);
        end
        step();
        checks++;
        if (bus.dm_done !== 1'b1 || bus.ram_wr !== 1'b0) begin
            errors++;
            $display("FAIL io_done: got done=%b wr=%b expected 1/0", bus.dm_done, bus.ram_wr);
        end
        bus.dm_req  = 1'b0;
        bus.dm_we   = 1'b0;
        bus.io_full = 1'b0;
        step();
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        checks       = 0;
        errors       = 0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_len   = 2'd0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.io_full  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        #1;
        mem[10'h100] <= 8'h13;
        mem[10'h101] <= 8'h05;
        mem[10'h104] <= 8'h93;
        mem[10'h106] <= 8'h10;
        mem[10'h040] <= 8'h34;
        mem[10'h041] <= 8'h12;
        step();
        test_reset();
        test_fetch();
        test_store_load();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_io_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
